// File: rtl/div_eval_pkg.sv
// Shared definitions for the divider error-evaluation blocks: default widths
// and the accumulator FSM state encoding.
package div_eval_pkg;

  localparam int DW_DEF = 8;
  localparam int CW_DEF = 16;
  localparam int SW_DEF = 24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/div_abs_diff.sv
// Combinational unsigned absolute difference |a-b| of two DW-bit operands.
module div_abs_diff #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  assign y = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/div_error_accumulator.sv
// Accumulates error statistics between an approximate and an exact divider
// over a run of num_samples result pairs, through a two-stage pipeline.
module div_error_accumulator
  import div_eval_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_samples,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] q_apx,
  input  logic [DW-1:0] r_apx,
  input  logic [DW-1:0] q_ex,
  input  logic [DW-1:0] r_ex,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] sum_q_err,
  output logic [SW-1:0] sum_r_err,
  output logic [DW-1:0] max_q_err,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] smp_cnt
);

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d, acc_cnt_q, acc_cnt_d;
  logic          s1_vld_q, s1_vld_d, s1_mis_q, s1_mis_d;
  logic [DW-1:0] s1_dq_q, s1_dq_d, s1_dr_q, s1_dr_d;
  logic          was_done_q, was_done_d, done_q, done_d;
  logic [SW-1:0] sum_q_err_q, sum_q_err_d, sum_r_err_q, sum_r_err_d;
  logic [DW-1:0] max_q_err_q, max_q_err_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d, smp_cnt_q, smp_cnt_d;
  logic [DW-1:0] dq_w, dr_w;
  logic          accept;

  div_abs_diff #(.DW(DW)) u_abs_q (.a(q_apx), .b(q_ex), .y(dq_w));
  div_abs_diff #(.DW(DW)) u_abs_r (.a(r_apx), .b(r_ex), .y(dr_w));

  assign in_ready = (state_q == S_RUN) && (acc_cnt_q < n_q);
  // start takes priority over a sample offered on the same cycle
  assign accept   = in_valid && in_ready && !start;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    acc_cnt_d   = acc_cnt_q;
    s1_vld_d    = accept;
    s1_dq_d     = dq_w;
    s1_dr_d     = dr_w;
    s1_mis_d    = (q_apx != q_ex) || (r_apx != r_ex);
    sum_q_err_d = sum_q_err_q;
    sum_r_err_d = sum_r_err_q;
    max_q_err_d = max_q_err_q;
    err_cnt_d   = err_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    // done fires on the second cycle spent in DONE
    was_done_d  = (state_q == S_DONE) && !start;
    done_d      = (state_q == S_DONE) && !was_done_q && !start;

    if (s1_vld_q) begin
      sum_q_err_d = sum_q_err_q + SW'(s1_dq_q);
      sum_r_err_d = sum_r_err_q + SW'(s1_dr_q);
      if (s1_dq_q > max_q_err_q) max_q_err_d = s1_dq_q;
      err_cnt_d   = err_cnt_q + CW'(s1_mis_q);
      smp_cnt_d   = smp_cnt_q + 1'b1;
    end

    case (state_q)
      S_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (acc_cnt_d == n_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!s1_vld_q) state_d = S_DONE;
      end
      default: ;
    endcase

    // start from any state restarts with a flushed pipeline and clean stats
    if (start) begin
      n_d         = num_samples;
      acc_cnt_d   = '0;
      s1_vld_d    = 1'b0;
      sum_q_err_d = '0;
      sum_r_err_d = '0;
      max_q_err_d = '0;
      err_cnt_d   = '0;
      smp_cnt_d   = '0;
      state_d     = (num_samples == '0) ? S_DONE : S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      acc_cnt_q   <= '0;
      s1_vld_q    <= 1'b0;
      s1_mis_q    <= 1'b0;
      s1_dq_q     <= '0;
      s1_dr_q     <= '0;
      was_done_q  <= 1'b0;
      done_q      <= 1'b0;
      sum_q_err_q <= '0;
      sum_r_err_q <= '0;
      max_q_err_q <= '0;
      err_cnt_q   <= '0;
      smp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      acc_cnt_q   <= acc_cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_mis_q    <= s1_mis_d;
      s1_dq_q     <= s1_dq_d;
      s1_dr_q     <= s1_dr_d;
      was_done_q  <= was_done_d;
      done_q      <= done_d;
      sum_q_err_q <= sum_q_err_d;
      sum_r_err_q <= sum_r_err_d;
      max_q_err_q <= max_q_err_d;
      err_cnt_q   <= err_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = done_q;
  assign sum_q_err = sum_q_err_q;
  assign sum_r_err = sum_r_err_q;
  assign max_q_err = max_q_err_q;
  assign err_cnt   = err_cnt_q;
  assign smp_cnt   = smp_cnt_q;

endmodule
